// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;
  localparam int PC_W    = 16;
  localparam int INSTR_W = 32;
  localparam logic [PC_W-1:0] PC_INC = 16'd4;

  typedef enum logic [1:0] {IDLE, WAIT, SQUASH} state_t;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] a);
    return {a[PC_W-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/fetch_fifo.sv
// Two-entry queue of {pc, instr}; head is held in a register so outputs are flop-driven.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wdata,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head
);
  fetch_entry_t slot1;
  logic [1:0]   count;
  logic         pop_ok, push_ok;

  assign full    = (count == 2'(DEPTH));
  assign empty   = (count == 2'd0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head  <= '0;
      slot1 <= '0;
      count <= 2'd0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      unique case ({push_ok, pop_ok})
        2'b10: begin
          if (count == 2'd0) head <= wdata;
          else               slot1 <= wdata;
          count <= count + 2'd1;
        end
        2'b01: begin
          head  <= slot1;
          count <= count - 2'd1;
        end
        2'b11: begin
          // Simultaneous push/pop: new word lands wherever the head will next read.
          if (count == 2'd1) head <= wdata;
          else begin
            head  <= slot1;
            slot1 <= wdata;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/inst_fetch.sv
// Fetch stage: owns the PC, issues one imem read at a time, queues PC-tagged words for decode.
module inst_fetch
  import fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 16'h0000,
  parameter int              DEPTH    = 2
) (
  input  logic               clock,
  input  logic               reset_n,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ready,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [INSTR_W-1:0] if_instr,
  output logic [PC_W-1:0]    if_pc
);
  state_t          state, state_nxt;
  logic [PC_W-1:0] pc, req_pc;
  logic            accept, push, pop, full, empty;
  fetch_entry_t    head, wdata;

  // Issuing only from IDLE with a free slot guarantees the response always fits.
  assign imem_req  = reset_n && (state == IDLE) && !full && !redirect;
  assign imem_addr = pc;
  assign accept    = imem_req && imem_ready;

  assign push  = (state == WAIT) && imem_rvalid && !redirect;
  assign wdata = '{pc: req_pc, instr: imem_rdata};

  assign if_valid = !empty && !redirect;
  assign pop      = if_valid && if_ready;
  assign if_instr = head.instr;
  assign if_pc    = head.pc;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .flush   (redirect),
    .wdata   (wdata),
    .full    (full),
    .empty   (empty),
    .head    (head)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = WAIT;
      WAIT: begin
        if (imem_rvalid)   state_nxt = IDLE;
        else if (redirect) state_nxt = SQUASH;
      end
      SQUASH:  if (imem_rvalid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      pc     <= RESET_PC;
      req_pc <= RESET_PC;
    end else begin
      state <= state_nxt;
      if (redirect) begin
        pc <= align_pc(redirect_pc);
      end else if (accept) begin
        req_pc <= pc;
        pc     <= pc + PC_INC;
      end
    end
  end
endmodule

// File: tb/tb_inst_fetch.sv
// Directed + random bench for inst_fetch with a latency-programmable memory and a sequential-PC scoreboard.
module tb_inst_fetch;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        imem_req, imem_ready = 1'b0, imem_rvalid = 1'b0;
  logic [15:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic        if_valid, if_ready = 1'b0;
  logic [31:0] if_instr;
  logic [15:0] if_pc;

  always #5 clock = ~clock;

  inst_fetch #(.RESET_PC(16'h0000), .DEPTH(2)) dut (
    .clock(clock), .reset_n(reset_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc)
  );

  int n_assert = 0, n_fail = 0, cyc = 0, n_pop = 0, lat = 1, mem_cnt = 0;
  bit mem_busy = 0, acc_s, rv_s;
  logic [15:0] mem_addr, acc_addr_s, exp_pc, exp_req;
  int          acc_cyc[$], pop_cyc[$];
  logic [15:0] acc_addr[$], pop_pc[$];
  logic [31:0] pop_instr[$];

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    case (a)
      16'h0000: return 32'h00004024;
      16'h0004: return 32'h00084825;
      16'h0008: return 32'h00095020;
      default:  return {a ^ 16'hA5C3, a};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    acc_cyc.delete(); acc_addr.delete(); pop_cyc.delete(); pop_pc.delete(); pop_instr.delete();
  endtask

  // One clock: check at the falling edge, then advance the memory model after the rising edge.
  task automatic tick();
    @(negedge clock);
    acc_s = 0;
    rv_s  = imem_rvalid;
    if (!reset_n) begin
      exp_pc  = 16'h0000;
      exp_req = 16'h0000;
    end else begin
      if (mem_busy) chk("no_req_while_busy", imem_req, 0);
      chk("addr_align", imem_addr[1:0], 0);
      if (redirect) begin
        chk("redirect_mask_valid", if_valid, 0);
        chk("redirect_no_req", imem_req, 0);
        exp_pc  = redirect_pc & 16'hFFFC;
        exp_req = exp_pc;
      end else begin
        if (imem_req && imem_ready) begin
          acc_s = 1;
          acc_addr_s = imem_addr;
          chk("req_addr", imem_addr, exp_req);
          acc_cyc.push_back(cyc);
          acc_addr.push_back(imem_addr);
          exp_req += 16'd4;
        end
        if (if_valid && if_ready) begin
          chk("out_pc", if_pc, exp_pc);
          chk("out_instr", if_instr, mem_word(exp_pc));
          pop_cyc.push_back(cyc);
          pop_pc.push_back(if_pc);
          pop_instr.push_back(if_instr);
          n_pop++;
          exp_pc += 16'd4;
        end
      end
    end
    @(posedge clock);
    #1;
    cyc++;
    if (!reset_n) begin
      mem_busy    = 0;
      imem_rvalid = 0;
    end else begin
      if (rv_s) mem_busy = 0;
      if (acc_s) begin
        mem_busy = 1;
        mem_cnt  = lat;
        mem_addr = acc_addr_s;
      end
      imem_rvalid = 0;
      if (mem_busy) begin
        mem_cnt--;
        if (mem_cnt == 0) begin
          imem_rvalid = 1;
          imem_rdata  = mem_word(mem_addr);
        end
      end
    end
  endtask

  task automatic restart();
    reset_n = 0;
    imem_rvalid = 0;
    tick();
    reset_n = 1;
    clear_logs();
  endtask

  initial begin
    imem_ready = 1; if_ready = 1; lat = 1;
    repeat (2) tick();
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 16'h0000);
    chk("rst_valid", if_valid, 0);
    chk("rst_instr", if_instr, 0);
    chk("rst_pc", if_pc, 0);

    // Startup fetch with a 1-cycle memory
    reset_n = 1;
    clear_logs();
    repeat (8) tick();
    chk("start_pops", pop_cyc.size() >= 3, 1);
    chk("start_addr0", acc_addr[0], 16'h0000);
    chk("start_addr1", acc_addr[1], 16'h0004);
    chk("start_addr2", acc_addr[2], 16'h0008);
    chk("start_out0", {pop_pc[0], pop_instr[0]}, {16'h0000, 32'h00004024});
    chk("start_out1", {pop_pc[1], pop_instr[1]}, {16'h0004, 32'h00084825});
    chk("start_out2", {pop_pc[2], pop_instr[2]}, {16'h0008, 32'h00095020});
    chk("start_latency", pop_cyc[0] - acc_cyc[0], 2);
    chk("start_rate1", pop_cyc[1] - pop_cyc[0], 2);
    chk("start_rate2", pop_cyc[2] - pop_cyc[1], 2);

    // Backpressure
    restart();
    if_ready = 0;
    repeat (8) tick();
    #1;
    chk("bp_req_low", imem_req, 0);
    chk("bp_valid", if_valid, 1);
    chk("bp_head", {if_pc, if_instr}, {16'h0000, 32'h00004024});
    if_ready = 1;
    tick();
    if_ready = 0;
    #1;
    chk("bp_next_head", {if_pc, if_instr}, {16'h0004, 32'h00084825});
    chk("bp_req_again", imem_req, 1);
    chk("bp_req_addr", imem_addr, 16'h0008);

    // Squash a slow read
    restart();
    if_ready = 1;
    lat = 3;
    tick();
    lat = 1;
    redirect = 1; redirect_pc = 16'h0040;
    #1;
    chk("sq_mask", if_valid, 0);
    tick();
    redirect = 0;
    repeat (6) tick();
    chk("sq_acc_cnt", acc_addr.size() >= 2, 1);
    chk("sq_new_addr", acc_addr[1], 16'h0040);
    chk("sq_issue_gap", acc_cyc[1] - acc_cyc[0], 4);
    chk("sq_first_out", {pop_pc[0], pop_instr[0]}, {16'h0040, mem_word(16'h0040)});

    // Alignment and wrap
    redirect = 1; redirect_pc = 16'h0043;
    tick();
    redirect = 0;
    #1;
    chk("align_addr", imem_addr, 16'h0040);
    repeat (4) tick();
    redirect = 1; redirect_pc = 16'hFFFC;
    tick();
    redirect = 0;
    clear_logs();
    repeat (8) tick();
    chk("wrap_addr0", acc_addr[0], 16'hFFFC);
    chk("wrap_addr1", acc_addr[1], 16'h0000);

    // Redirect and pop in the same cycle with a full queue
    if_ready = 0;
    repeat (8) tick();
    #1;
    chk("rp_full_req", imem_req, 0);
    redirect = 1; redirect_pc = 16'h0100; if_ready = 1;
    #1;
    chk("rp_mask", if_valid, 0);
    tick();
    redirect = 0;
    clear_logs();
    #1;
    chk("rp_flushed", if_valid, 0);
    repeat (6) tick();
    chk("rp_first_out", pop_pc[0], 16'h0100);

    // Reset while a read is outstanding
    restart();
    if_ready = 0; lat = 3;
    repeat (6) tick();
    #1;
    chk("rw_pre_valid", if_valid, 1);
    reset_n = 0;
    imem_rvalid = 0;
    #1;
    chk("rw_req", imem_req, 0);
    chk("rw_addr", imem_addr, 16'h0000);
    chk("rw_valid", if_valid, 0);
    chk("rw_instr", if_instr, 0);
    chk("rw_pc", if_pc, 0);
    tick();
    reset_n = 1; lat = 1;
    #1;
    chk("rw_restart_req", imem_req, 1);
    chk("rw_restart_addr", imem_addr, 16'h0000);

    // Random traffic against the scoreboard
    n_pop = 0;
    repeat (600) begin
      tick();
      if_ready    = ($urandom_range(0, 3) != 0);
      imem_ready  = ($urandom_range(0, 3) != 0);
      lat         = $urandom_range(1, 3);
      redirect    = ($urandom_range(0, 15) == 0);
      redirect_pc = 16'($urandom());
    end
    redirect = 0;
    tick();
    chk("random_progress", n_pop > 40, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch stage for the 16-bit single-cycle MIPS datapath. It owns the program counter and issues word-aligned reads to instruction memory, one outstanding at a time. Returned instructions are buffered, tagged with their PC, in a 2-entry queue and handed to the decode/register-file stage over a valid/ready handshake. A redirect input from branch resolution flushes the queue and squashes any in-flight read.

## Interface
- RESET_PC, 16'h0000, PC loaded on reset; bits [1:0] must be 0
- DEPTH, 2, instruction queue entries; fixed at 2 for this revision
- clock  in  1  single clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- imem_req  out  1  read request; held until accepted
- imem_addr  out  16  byte address of the request; [1:0] always 0
- imem_ready  in  1  memory accepts the request when imem_req && imem_ready
- imem_rvalid  in  1  read data valid; arrives at least 1 cycle after acceptance
- imem_rdata  in  32  instruction word
- redirect  in  1  flush and restart fetch at redirect_pc
- redirect_pc  in  16  new PC; bits [1:0] are ignored (forced to 0)
- if_valid  out  1  queue head holds an instruction
- if_ready  in  1  consumer takes the head when if_valid && if_ready
- if_instr  out  32  head instruction
- if_pc  out  16  byte address of the head instruction

## Operation
- The FSM has three states. IDLE means no read is outstanding. WAIT means one read is outstanding and its data will be kept. SQUASH means one read is outstanding and its data will be dropped.
- Issue rule: imem_req = reset_n && state==IDLE && count<DEPTH && !redirect. imem_addr = pc.
- On acceptance, req_pc <= pc, pc <= pc+4 (16-bit, wraps modulo 2^16), and the state moves IDLE->WAIT.
- WAIT with imem_rvalid: push {req_pc, imem_rdata} into the queue, then go to IDLE. A slot is always free because issue reserved it.
- SQUASH with imem_rvalid: drop the data, then go to IDLE.
- imem_rvalid in IDLE is ignored.
- Pop: when if_valid && if_ready, advance the head. A push and a pop in the same cycle leave count unchanged.
- Redirect has the highest priority and takes effect in the cycle it is asserted:
  - count <= 0 and the queue is flushed.
  - pc <= {redirect_pc[15:2], 2'b00}.
  - if_valid is masked to 0 and any pop that cycle is ignored.
  - WAIT without rvalid goes to SQUASH. WAIT with rvalid drops the data and goes to IDLE.
  - SQUASH stays in SQUASH, or goes to IDLE if rvalid arrives that cycle.
  - IDLE stays IDLE; no request is issued that cycle.
- Reset values: pc=RESET_PC, state=IDLE, count=0, if_valid=0, if_instr=0, if_pc=0, imem_req=0 while reset_n is low, imem_addr=RESET_PC.
- Reset mid-operation discards the queue and any outstanding read. Instruction memory shares reset_n, so no stale rvalid follows reset.

## Timing
- imem_req and imem_addr are combinational from registered state plus redirect. They have no path from imem_ready or imem_rvalid.
- if_valid, if_instr and if_pc are driven from queue registers, with if_valid additionally masked by redirect.
- With a 1-cycle memory: accepted at cycle T, rvalid at T+1, if_valid at T+2.
- Sustained throughput is 1 instruction per 2 cycles, because the next issue waits for IDLE.
- With if_ready=0, the queue fills after 2 responses and imem_req stays low until a pop.
- After a redirect in cycle R, the first request to the new PC is in cycle R+1 if IDLE. From SQUASH, it is in the cycle after the squashed rvalid.

## Structure
- fetch_pkg holds the state enum (IDLE, WAIT, SQUASH), PC_INC=4, and the widths PC_W=16 and INSTR_W=32.
- Sub-module fetch_fifo: a 2-entry, 48-bit queue with push, pop, flush, full, empty and head outputs. Flush takes priority over push. Read data comes from registered head.
- The top level holds pc, req_pc, the FSM and the issue logic.

## Test plan
- Startup fetch: release reset with a 1-cycle memory returning 32'h00004024, 32'h00084825, 32'h00095020 at addresses 0x0000, 0x0004, 0x0008, and if_ready=1.
  - Required: imem_addr sequence 0,4,8.
  - Required: if_instr/if_pc of 00004024/0000, 00084825/0004, 00095020/0008, one every 2 cycles.
- Backpressure: hold if_ready=0.
  - Required: after 2 responses, imem_req=0 and if_instr holds 00004024, if_pc 0000.
  - Required: raising if_ready for 1 cycle gives if_instr 00084825, then a new request to 0x0008.
- Squash: assert redirect with redirect_pc=16'h0040 while in WAIT, memory responding 3 cycles later.
  - Required: the late word is never presented.
  - Required: next imem_addr=0x0040 and the first output has if_pc=0x0040.
- Alignment and wrap: redirect_pc=16'h0043 gives imem_addr 0x0040. redirect_pc=16'hFFFC followed by a fetch gives next imem_addr 0x0000.
- Redirect and pop in the same cycle: with 2 entries queued, assert redirect and if_ready together.
  - Required: if_valid=0 that cycle and count=0 afterwards.
  - Required: no instruction from the flushed queue appears.
- Reset mid-WAIT: drop reset_n while a read is outstanding.
  - Required: all outputs go to their reset values immediately.
  - Required: after release, imem_req=1 with imem_addr=RESET_PC.
